alarm_ringer: RTL and testbench
===============================

Name: alarm_ringer

Overview:
- Consumer end of the alarm-match signal `judge` produced by the time/alarm comparator.
- On a new match, sounds a gated beep pattern on the buzzer for a bounded ring window.
- Supports stop, limited snooze with automatic re-ring, and re-arming once the match minute has passed.
- Sits between the comparator and the board buzzer/LED pins; clocked by the system clock, timed by the 1 Hz strobe from the clock divider.

Parameters:
- RING_SECS, 60: ring window length in 1 Hz ticks before auto-stop.
- SNOOZE_SECS, 300: snooze length in 1 Hz ticks before re-ring.
- MAX_SNOOZE, 3: maximum snoozes per alarm event.
- BEEP_HALF, 25000000: CLK cycles per buzzer on/off half-period.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  one-CLK-cycle strobe, once per second.
- judge  in  1  alarm-match level from comparator; stays high for the whole matching minute.
- EN_work  in  1  high = user in time/alarm setting mode.
- btn_stop  in  1  debounced single-cycle stop pulse.
- btn_snooze  in  1  debounced single-cycle snooze pulse.
- buzzer  out  1  beep drive.
- ringing  out  1  high while in RING.
- snoozing  out  1  high while in SNOOZE.
- snooze_cnt  out  $clog2(MAX_SNOOZE+1)  snoozes used in the current event.

Behaviour:
- Reset (async, RST_n=0):
  - state=IDLE; buzzer=0, ringing=0, snoozing=0, snooze_cnt=0.
  - sec_cnt=0, beep_cnt=0.
  - judge_d=1, so a judge already high at reset release does not trigger.
- Edge detect: judge_d registers judge every cycle; rise = judge & ~judge_d.
- All outputs are registered and updated on the same edge as the state.
  - ringing/snoozing follow the state.
  - Latency: rise sampled at edge k gives ringing=1 and buzzer=1 after edge k.
- IDLE:
  - rise & !EN_work -> RING; sec_cnt=0, beep_cnt=0, snooze_cnt=0.
  - rise while EN_work=1 is ignored; the event is lost for that minute.
- RING:
  - Priority, highest first: EN_work=1 > btn_stop > btn_snooze > timeout.
  - EN_work=1 -> DONE.
  - btn_stop -> DONE.
  - btn_snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; sec_cnt=0.
  - btn_snooze with snooze_cnt==MAX_SNOOZE is ignored; ringing continues.
  - tick_1hz with sec_cnt==RING_SECS-1 -> DONE; otherwise tick_1hz increments sec_cnt.
- SNOOZE:
  - EN_work=1 or btn_stop -> DONE.
  - tick_1hz with sec_cnt==SNOOZE_SECS-1 -> RING; sec_cnt=0, beep_cnt=0.
  - btn_snooze is ignored.
- DONE:
  - Outputs are 0; snooze_cnt holds its final value.
  - judge==0 -> IDLE. Prevents re-trigger within the same match minute.
- Buzzer:
  - Only in RING. beep_cnt counts 0..BEEP_HALF-1 and wraps.
  - buzzer toggles on wrap.
  - Entering RING forces buzzer=1 and beep_cnt=0.
  - Leaving RING forces buzzer=0 on the same edge.
- Counters:
  - sec_cnt width = $clog2(max(RING_SECS,SNOOZE_SECS)).
  - sec_cnt never wraps; the terminal value always causes a state exit.
- A tick_1hz coinciding with a button pulse: the button transition wins and the tick is dropped.

Optional Feature:
- Macro: ALARM_ESCALATE_EN.
- Defined:
  - Effective beep half-period in RING = BEEP_HALF >> snooze_cnt.
  - Minimum effective half-period is 1.
  - Each re-ring beeps faster.
- Undefined: half-period is always BEEP_HALF.

Test Plan:
- Bench parameters: RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2, BEEP_HALF=2.
- Basic ring and timeout:
  - Stimulus: judge 0->1 with EN_work=0.
  - Required: ringing=1 and buzzer=1 next edge; buzzer toggles every 2 cycles.
  - Required: 4th tick -> DONE, all outputs 0.
  - Required: judge held high keeps DONE; judge=0 -> IDLE.
- Snooze limit:
  - Stimulus: snooze in RING.
  - Required: snoozing=1, snooze_cnt=1; 3 ticks later ringing=1.
  - Stimulus: repeat snooze.
  - Required: snooze_cnt=2.
  - Stimulus: 3rd snooze.
  - Required: ignored; ringing stays 1.
- Stop and priority:
  - Stimulus: btn_stop and btn_snooze in the same cycle during RING.
  - Required: DONE, snooze_cnt unchanged.
  - Stimulus: btn_stop during SNOOZE.
  - Required: DONE.
- Setting mode:
  - Stimulus: EN_work=1 during RING.
  - Required: buzzer=0 next edge, DONE.
  - Stimulus: judge rise while EN_work=1.
  - Required: stays IDLE.
- Reset:
  - Stimulus: RST_n low mid-RING.
  - Required: all outputs 0 immediately.
  - Stimulus: release with judge=1.
  - Required: no ring until judge falls and rises again.
- ALARM_ESCALATE_EN (BEEP_HALF=4):
  - Stimulus: after 1 snooze, re-ring.
  - Required: buzzer toggles every 2 cycles.

Source files
------------

// File: rtl/alarm_ringer.sv
// ---------------------------------------------------------------------------
// alarm_ringer
//
// Consumer end of the alarm-match level `judge`. On a fresh match it rings a
// gated beep pattern for a bounded window. It also supports stop, a limited
// number of snoozes with automatic re-ring, and re-arming once the match
// minute has passed (judge falls).
//
// Ports
//   CLK         in   system clock, all state on the rising edge
//   RST_n       in   asynchronous active-low reset
//   tick_1hz    in   one-cycle strobe, once per second
//   judge       in   alarm-match level, high for the whole matching minute
//   EN_work     in   high while the user is in time/alarm setting mode
//   btn_stop    in   debounced single-cycle stop pulse
//   btn_snooze  in   debounced single-cycle snooze pulse
//   buzzer      out  beep drive (toggles every effective half-period in RING)
//   ringing     out  high while in RING
//   snoozing    out  high while in SNOOZE
//   snooze_cnt  out  snoozes used in the current alarm event
//   state_dbg   out  current FSM state (0 IDLE, 1 RING, 2 SNOOZE, 3 DONE)
//
// Signalling: there is no valid/ready handshake here. tick_1hz, btn_stop and
// btn_snooze are single-cycle pulses sampled on the rising edge of CLK and
// never back-pressured; a pulse not acted on in its cycle is simply dropped.
// judge is a level; only its rising edge starts an alarm.
//
// Optional build macro: ALARM_ESCALATE_EN
//   defined   -> beep half-period in RING is BEEP_HALF >> snooze_cnt (min 1),
//                so each re-ring beeps faster
//   undefined -> beep half-period is always BEEP_HALF
// ---------------------------------------------------------------------------
module alarm_ringer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int BEEP_HALF   = 25000000,
  localparam int SC_W       = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            tick_1hz,
  input  logic            judge,
  input  logic            EN_work,
  input  logic            btn_stop,
  input  logic            btn_snooze,
  output logic            buzzer,
  output logic            ringing,
  output logic            snoozing,
  output logic [SC_W-1:0] snooze_cnt,
  output logic [1:0]      state_dbg
);

  localparam int SEC_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int BEEP_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SECS - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);
  localparam logic [SC_W-1:0]  MAX_SC      = SC_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              judge_d;
  logic              rise;
  logic [SEC_W-1:0]  sec_cnt, sec_nxt;
  logic [BEEP_W-1:0] beep_cnt, beep_nxt;
  logic [BEEP_W-1:0] beep_last;
  logic [SC_W-1:0]   sc_nxt;
  logic              buzzer_nxt, ringing_nxt, snoozing_nxt;

  assign rise      = judge & ~judge_d;
  assign state_dbg = state;

  // Last beep_cnt value of a half-period.
`ifdef ALARM_ESCALATE_EN
  logic [31:0] half_eff;
  always_comb begin
    half_eff = 32'(BEEP_HALF) >> snooze_cnt;
    if (half_eff == 32'd0) half_eff = 32'd1;
    beep_last = BEEP_W'(half_eff - 32'd1);
  end
`else
  assign beep_last = BEEP_W'(BEEP_HALF - 1);
`endif

  // State register plus all registered outputs and counters. judge_d resets
  // high so a judge already asserted at reset release is not seen as a rise.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      judge_d    <= 1'b1;
      sec_cnt    <= '0;
      beep_cnt   <= '0;
      snooze_cnt <= '0;
      buzzer     <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state      <= state_nxt;
      judge_d    <= judge;
      sec_cnt    <= sec_nxt;
      beep_cnt   <= beep_nxt;
      snooze_cnt <= sc_nxt;
      buzzer     <= buzzer_nxt;
      ringing    <= ringing_nxt;
      snoozing   <= snoozing_nxt;
    end
  end

  // Next-state logic. Button transitions sit above the tick branch, so a
  // tick that coincides with an accepted button press is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise && !EN_work) state_nxt = RING;
      end
      RING: begin
        if (EN_work || btn_stop)                     state_nxt = DONE;
        else if (btn_snooze && (snooze_cnt < MAX_SC)) state_nxt = SNOOZE;
        else if (tick_1hz && (sec_cnt == RING_LAST))  state_nxt = DONE;
      end
      SNOOZE: begin
        if (EN_work || btn_stop)                       state_nxt = DONE;
        else if (tick_1hz && (sec_cnt == SNOOZE_LAST)) state_nxt = RING;
      end
      DONE: begin
        // Wait out the match minute so the same match cannot re-trigger.
        if (!judge) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    sec_nxt      = sec_cnt;
    beep_nxt     = '0;
    buzzer_nxt   = 1'b0;
    sc_nxt       = snooze_cnt;
    ringing_nxt  = (state_nxt == RING);
    snoozing_nxt = (state_nxt == SNOOZE);

    // Any state change restarts the second counter; otherwise ticks count.
    // The terminal count always forces an exit, so sec_cnt never wraps.
    if (state_nxt != state) begin
      sec_nxt = '0;
    end else if (tick_1hz && ((state == RING) || (state == SNOOZE))) begin
      sec_nxt = sec_cnt + 1'b1;
    end

    // Buzzer only runs in RING; entry starts a fresh "on" half-period.
    if (state_nxt == RING) begin
      if (state != RING) begin
        beep_nxt   = '0;
        buzzer_nxt = 1'b1;
      end else if (beep_cnt == beep_last) begin
        beep_nxt   = '0;
        buzzer_nxt = ~buzzer;
      end else begin
        beep_nxt   = beep_cnt + 1'b1;
        buzzer_nxt = buzzer;
      end
    end

    if ((state == IDLE) && (state_nxt == RING)) begin
      sc_nxt = '0;
    end else if ((state == RING) && (state_nxt == SNOOZE)) begin
      sc_nxt = snooze_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// ---------------------------------------------------------------------------
// tb_alarm_ringer
//
// Directed bench for alarm_ringer with RING_SECS=4, SNOOZE_SECS=3,
// MAX_SNOOZE=2, BEEP_HALF=2 (BEEP_HALF=4 when ALARM_ESCALATE_EN is defined).
// Stimulus tasks drive one cycle of inputs at the falling edge and push the
// hand-computed output vector expected after the following rising edge into
// exp_q, tagged with that edge number. A monitor samples 1 time unit after
// each rising edge and compares entries whose tag matches. Entries tagged -1
// are checked 1 time unit after RST_n falls (asynchronous reset response).
// ---------------------------------------------------------------------------
module tb_alarm_ringer;

  localparam int RING_SECS   = 4;
  localparam int SNOOZE_SECS = 3;
  localparam int MAX_SNOOZE  = 2;
`ifdef ALARM_ESCALATE_EN
  localparam int BEEP_HALF   = 4;
  localparam bit ESC         = 1'b1;
`else
  localparam int BEEP_HALF   = 2;
  localparam bit ESC         = 1'b0;
`endif

  localparam int ST_IDLE   = 0;
  localparam int ST_RING   = 1;
  localparam int ST_SNOOZE = 2;
  localparam int ST_DONE   = 3;

  logic       CLK;
  logic       RST_n;
  logic       tick_1hz;
  logic       judge;
  logic       EN_work;
  logic       btn_stop;
  logic       btn_snooze;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;
  logic [1:0] state_dbg;

  alarm_ringer #(
    .RING_SECS   (RING_SECS),
    .SNOOZE_SECS (SNOOZE_SECS),
    .MAX_SNOOZE  (MAX_SNOOZE),
    .BEEP_HALF   (BEEP_HALF)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .tick_1hz   (tick_1hz),
    .judge      (judge),
    .EN_work    (EN_work),
    .btn_stop   (btn_stop),
    .btn_snooze (btn_snooze),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int edge_n = 0;
  always @(posedge CLK) edge_n++;

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int         tag_q[$];
  string      name_q[$];
  int         checks   = 0;
  int         failures = 0;

  wire [6:0] dut_vec = {state_dbg, snooze_cnt, snoozing, ringing, buzzer};

  function automatic void compare(string nm, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual st=%0d sc=%0d sn=%0b rg=%0b bz=%0b required st=%0d sc=%0d sn=%0b rg=%0b bz=%0b",
               nm, act[6:5], act[4:3], act[2], act[1], act[0],
               exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endfunction

  function automatic void pop_front();
    void'(exp_q.pop_front());
    void'(tag_q.pop_front());
    void'(name_q.pop_front());
  endfunction

  // Monitor: compare every expectation tagged with the edge just taken.
  always @(posedge CLK) begin
    #1;
    while ((tag_q.size() > 0) && (tag_q[0] == edge_n)) begin
      compare(name_q[0], dut_vec, exp_q[0]);
      pop_front();
    end
  end

  // Asynchronous reset response, sampled before any clock edge.
  always @(negedge RST_n) begin
    #1;
    if ((tag_q.size() > 0) && (tag_q[0] == -1)) begin
      compare(name_q[0], dut_vec, exp_q[0]);
      pop_front();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(string nm, int tag, int st, int sc, logic sn, logic rg, logic bz);
    logic [1:0] st2;
    logic [1:0] sc2;
    st2 = st[1:0];
    sc2 = sc[1:0];
    exp_q.push_back({st2, sc2, sn, rg, bz});
    tag_q.push_back(tag);
    name_q.push_back(nm);
  endtask

  task automatic step(logic j, logic e, logic s, logic z, logic t);
    @(negedge CLK);
    judge      = j;
    EN_work    = e;
    btn_stop   = s;
    btn_snooze = z;
    tick_1hz   = t;
  endtask

  // One cycle of inputs plus the outputs expected after the next rising edge.
  task automatic cyc(string nm, logic j, logic e, logic s, logic z, logic t,
                     int st, int sc, logic sn, logic rg, logic bz);
    step(j, e, s, z, t);
    push_exp(nm, edge_n + 1, st, sc, sn, rg, bz);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] bz_seq;

  initial begin
    RST_n      = 1'b0;
    judge      = 1'b0;
    EN_work    = 1'b0;
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    tick_1hz   = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;

    cyc("reset_idle", 0,0,0,0,0, ST_IDLE, 0, 0,0,0);

    // Basic ring and timeout. Buzzer pattern for edges 2..8 after entry:
    // half-period 2 -> 1,0,0,1,1,0,0 ; half-period 4 -> 1,1,1,0,0,0,0.
    cyc("ring_start", 1,0,0,0,0, ST_RING, 0, 0,1,1);
    bz_seq = ESC ? 7'b1110000 : 7'b1001100;
    for (int i = 0; i < 7; i++) begin
      cyc($sformatf("beep_%0d", i), 1,0,0,0,(i >= 4), ST_RING, 0, 0,1, bz_seq[6-i]);
    end
    cyc("ring_timeout",  1,0,0,0,1, ST_DONE, 0, 0,0,0);
    cyc("done_hold",     1,0,0,0,0, ST_DONE, 0, 0,0,0);
    cyc("done_to_idle",  0,0,0,0,0, ST_IDLE, 0, 0,0,0);

    // Snooze limit.
    cyc("s2_ring",        1,0,0,0,0, ST_RING,   0, 0,1,1);
    cyc("snooze1",        1,0,0,1,0, ST_SNOOZE, 1, 1,0,0);
    cyc("snz_in_snooze",  1,0,0,1,0, ST_SNOOZE, 1, 1,0,0);
    cyc("snz1_tick1",     1,0,0,0,1, ST_SNOOZE, 1, 1,0,0);
    cyc("snz1_tick2",     1,0,0,0,1, ST_SNOOZE, 1, 1,0,0);
    cyc("rering1",        1,0,0,0,1, ST_RING,   1, 0,1,1);
    // Half-period 2 here in both builds (BEEP_HALF=4 >> 1 when escalating).
    cyc("rering_beep_a",  1,0,0,0,0, ST_RING,   1, 0,1,1);
    cyc("rering_beep_b",  1,0,0,0,0, ST_RING,   1, 0,1,0);
    cyc("rering_beep_c",  1,0,0,0,0, ST_RING,   1, 0,1,0);
    cyc("rering_beep_d",  1,0,0,0,0, ST_RING,   1, 0,1,1);
    cyc("snooze2",        1,0,0,1,0, ST_SNOOZE, 2, 1,0,0);
    cyc("snz2_tick1",     1,0,0,0,1, ST_SNOOZE, 2, 1,0,0);
    cyc("snz2_tick2",     1,0,0,0,1, ST_SNOOZE, 2, 1,0,0);
    cyc("rering2",        1,0,0,0,1, ST_RING,   2, 0,1,1);
    cyc("snooze_limit",   1,0,0,1,0, ST_RING,   2, 0,1, ESC ? 1'b0 : 1'b1);
    cyc("stop_ring",      1,0,1,0,0, ST_DONE,   2, 0,0,0);
    cyc("s2_idle",        0,0,0,0,0, ST_IDLE,   2, 0,0,0);

    // Stop priority, tick dropped on button, stop during snooze.
    cyc("s3_ring",           1,0,0,0,0, ST_RING,   0, 0,1,1);
    cyc("stop_beats_snooze", 1,0,1,1,0, ST_DONE,   0, 0,0,0);
    cyc("s3_idle_a",         0,0,0,0,0, ST_IDLE,   0, 0,0,0);
    cyc("s3_ring_b",         1,0,0,0,0, ST_RING,   0, 0,1,1);
    cyc("snooze_with_tick",  1,0,0,1,1, ST_SNOOZE, 1, 1,0,0);
    cyc("s3_tick1",          1,0,0,0,1, ST_SNOOZE, 1, 1,0,0);
    cyc("s3_tick2",          1,0,0,0,1, ST_SNOOZE, 1, 1,0,0);
    cyc("stop_in_snooze",    1,0,1,0,1, ST_DONE,   1, 0,0,0);
    cyc("s3_idle_b",         0,0,0,0,0, ST_IDLE,   1, 0,0,0);

    // Setting mode.
    cyc("s4_ring",          1,0,0,0,0, ST_RING,   0, 0,1,1);
    cyc("en_beats_snooze",  1,1,0,1,0, ST_DONE,   0, 0,0,0);
    cyc("en_done_hold",     1,1,0,0,0, ST_DONE,   0, 0,0,0);
    cyc("s4_idle",          0,1,0,0,0, ST_IDLE,   0, 0,0,0);
    cyc("rise_in_setting",  1,1,0,0,0, ST_IDLE,   0, 0,0,0);
    cyc("held_no_rise",     1,0,0,0,0, ST_IDLE,   0, 0,0,0);
    cyc("s4_judge_low",     0,0,0,0,0, ST_IDLE,   0, 0,0,0);
    cyc("s4_rearm",         1,0,0,0,0, ST_RING,   0, 0,1,1);
    cyc("s4_snooze",        1,0,0,1,0, ST_SNOOZE, 1, 1,0,0);
    cyc("en_in_snooze",     1,1,0,0,0, ST_DONE,   1, 0,0,0);
    cyc("s4_idle_b",        0,0,0,0,0, ST_IDLE,   1, 0,0,0);

    // Asynchronous reset mid-RING, released with judge high.
    cyc("s5_ring", 1,0,0,0,0, ST_RING, 0, 0,1,1);
    @(posedge CLK);
    #2;
    push_exp("async_reset", -1, ST_IDLE, 0, 0,0,0);
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    cyc("release_judge_high", 1,0,0,0,0, ST_IDLE, 0, 0,0,0);
    cyc("still_no_ring",      1,0,0,0,0, ST_IDLE, 0, 0,0,0);
    cyc("s5_judge_low",       0,0,0,0,0, ST_IDLE, 0, 0,0,0);
    cyc("s5_rearm",           1,0,0,0,0, ST_RING, 0, 0,1,1);
    cyc("s5_stop",            1,0,1,0,0, ST_DONE, 0, 0,0,0);
    cyc("s5_idle",            0,0,0,0,0, ST_IDLE, 0, 0,0,0);

    // Drain: every expectation must have been consumed by now.
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
